// File: rtl/inst_queue.sv
// Instruction prefetch queue between the MDR read bus and decode: first-word fall-through, zero-latency head.
// in_ready depends only on registered occupancy, so a pop does not make room until the next cycle; a rejected write pulses ovf.
module inst_queue #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage is never reset; it is unobservable while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= in_valid && !in_ready;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_inst_queue;

  localparam int WIDTH = 36;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       count;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_ovf = 1'b0;

  inst_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // One rising edge; the model follows the queue rules, then outputs settle for sampling.
  task automatic cycle();
    bit do_push, do_pop, nxt_ovf;
    do_push = in_valid && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    nxt_ovf = !rst && !flush && in_valid && (mq.size() == DEPTH);
    @(posedge clk);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(in_data);
    end
    m_ovf = nxt_ovf;
    #1;
  endtask

  function automatic logic [WIDTH-1:0] m_head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; rst = 0; in_data = '0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    in_valid = 1; in_data = w; out_ready = 0;
    cycle();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; cycle(); cycle(); rst = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== 36'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_first_word();
    push_word(36'h0_0000_0011);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwft_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 36'h0_0000_0011) begin errors++; $display("FAIL fwft_data: got %h want 11", out_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL fwft_count: got %0d want 1", count); end
    out_ready = 1; cycle(); out_ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fwft_drain: got %0d want 0", count); end
  endtask

  task automatic test_fill_ovf();
    for (int i = 1; i <= 4; i++) push_word(WIDTH'(i));
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", ovf); end
    push_word(36'h5);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", ovf); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", count); end
    cycle();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b want 0", ovf); end
  endtask

  task automatic test_full_pop();
    logic [WIDTH-1:0] exp_seq [4];
    int n;
    exp_seq[0] = 36'h2; exp_seq[1] = 36'h3; exp_seq[2] = 36'h4; exp_seq[3] = 36'h6;
    in_valid = 1; in_data = 36'h6; out_ready = 1;
    cycle();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
    checks++; if (out_data !== 36'h2) begin errors++; $display("FAIL fullpop_head: got %h want 2", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready: got %b want 1", in_ready); end
    out_ready = 0;
    cycle();
    in_valid = 0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill: got %0d want 4", count); end
    out_ready = 1; n = 0;
    for (int k = 0; k < 8 && out_valid; k++) begin
      if (n < 4) begin
        checks++; if (out_data !== exp_seq[n]) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", n, out_data, exp_seq[n]); end
      end
      n++;
      cycle();
    end
    out_ready = 0;
    checks++; if (n !== 4) begin errors++; $display("FAIL drain_len: got %0d want 4", n); end
  endtask

  task automatic test_stream();
    push_word(36'h100);
    in_valid = 1; out_ready = 1;
    for (int i = 1; i < 10; i++) begin
      in_data = WIDTH'(36'h100 + i);
      checks++; if (out_data !== WIDTH'(36'h100 + i - 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, 36'h100 + i - 1); end
      cycle();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, count); end
    end
    in_valid = 0;
    checks++; if (out_data !== 36'h109) begin errors++; $display("FAIL stream_last: got %h want 109", out_data); end
    cycle(); out_ready = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_empty: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    push_word(36'hA1); push_word(36'hA2); push_word(36'hA3);
    flush = 1; in_valid = 1; in_data = 36'hA4;
    cycle();
    flush = 0; in_valid = 0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 36'h0) begin errors++; $display("FAIL flush_data: got %h want 0", out_data); end
    push_word(36'hB0);
    checks++; if (out_data !== 36'hB0) begin errors++; $display("FAIL flush_after: got %h want b0", out_data); end
    out_ready = 1; cycle(); out_ready = 0;
  endtask

  task automatic test_rst_mid();
    push_word(36'hC1); push_word(36'hC2);
    rst = 1; flush = 1; in_valid = 1; in_data = 36'hC3; out_ready = 1;
    cycle();
    idle_inputs();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom(), $urandom()};
      in_data   = r[WIDTH-1:0];
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0) || (i > 1500 && $urandom_range(0, 1) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 127) == 0);
      cycle();
      checks++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d want %0d", i, count, mq.size()); end
      checks++; if (out_data !== m_head()) begin errors++; $display("FAIL rand_data@%0d: got %h want %h", i, out_data, m_head()); end
      checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_valid@%0d: got %b want %b", i, out_valid, mq.size() != 0); end
      checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rand_in_ready@%0d: got %b want %b", i, in_ready, mq.size() != DEPTH); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf@%0d: got %b want %b", i, ovf, m_ovf); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_ovf();
    test_full_pop();
    test_stream();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter WIDTH, default 36, SHALL set the instruction word width, carrying the MDR word unmodified.
REQ-002 Parameter DEPTH, default 4, SHALL set the entry count; legal values are powers of two, 2 to 16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 in_data  input  WIDTH  SHALL be the instruction word from the MDR read bus.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a word to enqueue.
REQ-007 in_ready  output  1  SHALL indicate that the queue accepts a word this cycle.
REQ-008 out_data  output  WIDTH  SHALL present the oldest queued word to decode.
REQ-009 out_valid  output  1  SHALL indicate that out_data is valid.
REQ-010 out_ready  input  1  SHALL indicate that decode consumes out_data this cycle.
REQ-011 flush  input  1  SHALL discard all queued words (branch redirect).
REQ-012 count  output  clog2(DEPTH+1)  SHALL report the current occupancy.
REQ-013 ovf  output  1  SHALL be a registered one-cycle pulse flagging a rejected write.

Function
REQ-014 Push SHALL occur when in_valid and in_ready are both 1 at a rising edge: word written at wr_ptr, wr_ptr advanced.
REQ-015 Pop SHALL occur when out_valid and out_ready are both 1 at a rising edge: rd_ptr advanced.
REQ-016 in_ready SHALL equal (count != DEPTH), combinational from registered count only; a pop does not free space in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL equal mem[rd_ptr] when out_valid is 1, else all zeros.
REQ-018 Queue SHALL be first-word fall-through: a word pushed at edge N appears on out_data immediately after edge N when the queue was empty.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; push only adds 1; pop only subtracts 1.
REQ-020 Pointers SHALL wrap modulo DEPTH; order SHALL be strictly FIFO across wrap.
REQ-021 Word content SHALL be opaque; no bit of in_data alters control behaviour.
REQ-022 flush at an edge SHALL clear count, wr_ptr, rd_ptr; a push or pop requested in that cycle SHALL be ignored.
REQ-023 Priority SHALL be rst > flush > push/pop.
REQ-024 ovf SHALL be 1 in the cycle after an edge where in_valid=1 and in_ready=0 with rst=0 and flush=0, else 0.
REQ-025 Pop on empty SHALL be impossible by construction (out_valid=0); count SHALL never underflow or exceed DEPTH.
REQ-026 Storage SHALL be registers; no combinational path from in_data to out_data.

Reset
REQ-027 On rst=1 at an edge: count=0, wr_ptr=0, rd_ptr=0, ovf=0; hence out_valid=0, in_ready=1, out_data=0.
REQ-028 Storage array contents SHALL NOT require reset; they are unobservable while count=0.
REQ-029 rst asserted mid-operation (queue non-empty, push/pop active) SHALL discard all words and override flush, push and pop.

Verification
REQ-030 Reset, then push 36'h0_0000_0011 once with out_ready=0 -> next cycle out_valid=1, out_data=36'h0_0000_0011, count=1.
REQ-031 Push 36'h1, 36'h2, 36'h3, 36'h4 with out_ready=0 -> count=4, in_ready=0; fifth push of 36'h5 -> ovf=1 for one cycle, count stays 4, 36'h5 never emerges.
REQ-032 Full queue, in_valid=1 and out_ready=1 together -> pop of 36'h1 only, count=3; next cycle in_ready=1 and push accepted.
REQ-033 Stream 10 words 36'h100..36'h109 with simultaneous push/pop each cycle after the first -> output order 36'h100..36'h109 across pointer wrap, count stable at 1.
REQ-034 Three words queued, flush=1 with in_valid=1 same cycle -> count=0, out_valid=0, out_data=0; the in-flight word is dropped.
REQ-035 Two words queued, rst=1 with flush=1, in_valid=1, out_ready=1 -> count=0, ovf=0, in_ready=1 on next cycle.
